// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory and IF/ID bundle between fetch (master) and memory/decode (slave).
interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [ADDR_WIDTH-1:0]  if_id_pc;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic                   if_id_valid;
  logic [10:0]            opcode_bits;
  logic [31:0]            fetch_count;
  modport master (
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, opcode_bits, fetch_count,
    input  imem_data
  );
  modport slave (
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, opcode_bits, fetch_count,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch and IF/ID register with branch redirect and stall.
// Define FETCH_COUNT_EN to build the fetched-instruction counter; otherwise fetch_count is 0.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PC_INCR     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  uncondbranch,
  input  logic                  zero,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  fetch_stage_if.master         bus
);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'hD503201F);
  typedef enum logic {S_RESET, S_RUN} state_t;
  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, if_pc_q, if_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d, redirect, load;
  always_comb begin
    redirect = uncondbranch | (branch & zero);
    load     = ~redirect & ~stall;
    pc_d     = redirect ? (branch_target & ~ADDR_WIDTH'(3)) : stall ? pc_q : pc_q + ADDR_WIDTH'(PC_INCR);
    if_pc_d  = redirect ? '0 : stall ? if_pc_q : pc_q;
    instr_d  = redirect ? NOP : stall ? instr_q : bus.imem_data;
    valid_d  = redirect ? 1'b0 : stall ? valid_q : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      if_pc_q <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= (state_q == S_RESET) ? S_RUN : state_q;
      pc_q    <= pc_d;
      if_pc_q <= if_pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
`ifdef FETCH_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign bus.fetch_count = cnt_q;
`else
  logic unused_load;
  assign unused_load     = load;
  assign bus.fetch_count = 32'd0;
`endif
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = if_pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_valid = valid_q;
  assign bus.opcode_bits = instr_q[INSTR_WIDTH-1 -: 11];
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus against a behavioural fetch model for two RESET_PC builds.
module tb_fetch_stage;
  localparam int CYCLE = 10;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic clk = 0, reset = 1, stall = 0, branch = 0, uncondbranch = 0, zero = 0;
  logic [63:0] branch_target = '0;
  logic ovr_en = 0, chk_en = 0;
  logic [31:0] ovr = '0;
  int pass_cnt = 0, tot_cnt = 0;
  always #(CYCLE/2) clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus0 ();
  fetch_stage_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus1 ();
  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .uncondbranch(uncondbranch),
    .zero(zero), .branch_target(branch_target), .bus(bus0));
  fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .uncondbranch(uncondbranch),
    .zero(zero), .branch_target(branch_target), .bus(bus1));

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return ovr_en ? ovr : (32'h1000_0000 | a[31:0]);
  endfunction
  assign bus0.imem_data = word_at(bus0.imem_addr);
  assign bus1.imem_data = word_at(bus1.imem_addr);

  // Model: each instance is a PC plus a one-entry IF/ID slot
  logic [63:0] rpc [2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFC};
  logic [63:0] m_pc [2], m_ipc [2];
  logic [31:0] m_instr [2], m_cnt [2];
  logic        m_valid [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pc[i] = rpc[i]; m_ipc[i] = 0; m_instr[i] = NOP; m_valid[i] = 0; m_cnt[i] = 0;
      end else if (uncondbranch || (branch && zero)) begin
        m_pc[i] = {branch_target[63:2], 2'b00}; m_ipc[i] = 0; m_instr[i] = NOP; m_valid[i] = 0;
      end else if (!stall) begin
        m_ipc[i] = m_pc[i]; m_instr[i] = word_at(m_pc[i]); m_valid[i] = 1;
        m_cnt[i] = m_cnt[i] + 1; m_pc[i] = m_pc[i] + 64'd4;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_inst(input int i, input logic [63:0] addr, input logic [63:0] ipc,
                          input logic [31:0] instr, input logic valid, input logic [10:0] opc,
                          input logic [31:0] cnt);
    logic [31:0] w;
    w = m_instr[i];
    check($sformatf("m%0d.imem_addr", i), addr, m_pc[i]);
    check($sformatf("m%0d.if_id_pc", i), ipc, m_ipc[i]);
    check($sformatf("m%0d.if_id_instr", i), {32'h0, instr}, {32'h0, w});
    check($sformatf("m%0d.if_id_valid", i), {63'h0, valid}, {63'h0, m_valid[i]});
    check($sformatf("m%0d.opcode_bits", i), {53'h0, opc}, {53'h0, w[31:21]});
`ifdef FETCH_COUNT_EN
    check($sformatf("m%0d.fetch_count", i), {32'h0, cnt}, {32'h0, m_cnt[i]});
`else
    check($sformatf("m%0d.fetch_count", i), {32'h0, cnt}, 64'h0);
`endif
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp_inst(0, bus0.imem_addr, bus0.if_id_pc, bus0.if_id_instr, bus0.if_id_valid,
             bus0.opcode_bits, bus0.fetch_count);
    cmp_inst(1, bus1.imem_addr, bus1.if_id_pc, bus1.if_id_instr, bus1.if_id_valid,
             bus1.opcode_bits, bus1.fetch_count);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    step(); chk_en = 1;
    step();
    check("rst.pc", bus0.imem_addr, 64'h0);
    check("rst.pc_w", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("rst.valid", {63'h0, bus0.if_id_valid}, 64'h0);
    check("rst.instr", {32'h0, bus0.if_id_instr}, {32'h0, NOP});
    check("rst.opcode", {53'h0, bus0.opcode_bits}, {53'h0, 11'b11010101000});
    reset = 0;
    step();
    check("seq.addr4", bus0.imem_addr, 64'h4);
    check("seq.instr0", {32'h0, bus0.if_id_instr}, 64'h1000_0000);
    check("seq.valid", {63'h0, bus0.if_id_valid}, 64'h1);
    check("seq.opcode", {53'h0, bus0.opcode_bits}, {53'h0, 11'b00010000000});
    check("wrap.pc", bus1.imem_addr, 64'h0);
    check("wrap.if_id_pc", bus1.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("seq.addr8", bus0.imem_addr, 64'h8);
    ovr_en = 1; ovr = 32'hF840_0000;
    step();
    ovr_en = 0;
    check("ldur.opcode", {53'h0, bus0.opcode_bits}, {53'h0, 11'b11111000010});
    check("ldur.addr12", bus0.imem_addr, 64'hC);
    stall = 1;
    repeat (3) begin
      step();
      check("stall.addr", bus0.imem_addr, 64'hC);
      check("stall.if_id_pc", bus0.if_id_pc, 64'h8);
    end
    stall = 0;
    step();
    check("unstall.addr", bus0.imem_addr, 64'h10);
    step();
    uncondbranch = 1; branch_target = 64'h103;
    step();
    uncondbranch = 0;
    check("b.pc", bus0.imem_addr, 64'h100);
    check("b.valid", {63'h0, bus0.if_id_valid}, 64'h0);
    check("b.instr", {32'h0, bus0.if_id_instr}, {32'h0, NOP});
    step();
    check("b.if_id_pc", bus0.if_id_pc, 64'h100);
    check("b.valid2", {63'h0, bus0.if_id_valid}, 64'h1);
    branch = 1; zero = 0; branch_target = 64'h300;
    step();
    check("cbz.nt", bus0.imem_addr, 64'h108);
    zero = 1; stall = 1; branch_target = 64'h200;
    step();
    branch = 0; zero = 0; stall = 0;
    check("cbz.t_stall", bus0.imem_addr, 64'h200);
    check("cbz.valid", {63'h0, bus0.if_id_valid}, 64'h0);
    repeat (2) step();
    reset = 1;
    step();
    reset = 0;
    check("mid_rst.pc", bus0.imem_addr, 64'h0);
    check("mid_rst.pc_w", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("mid_rst.valid", {63'h0, bus0.if_id_valid}, 64'h0);
    check("mid_rst.count", {32'h0, bus0.fetch_count}, 64'h0);
    repeat (3) step();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
